// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter.
//
// The display reader has absolute priority: a read request sampled at an
// edge owns the RAM port for the following cycle and returns its data with a
// fixed 3-cycle latency. Capture writes are queued in a small FIFO and drained
// into every cycle the reader leaves free.
//
// Handshakes:
//   rd_req            - single-cycle pulse, no back-pressure; the reader keeps
//                       at least one idle cycle between requests.
//   wr_valid/wr_ready - a beat transfers at an edge where both are high.
//                       wr_ready comes from registered occupancy only. A beat
//                       offered while wr_ready is low is dropped and flagged.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rd_req, rd_addr       display read request and word address
//   rd_valid, rd_data     read return (bit0 = leftmost pixel)
//   wr_valid, wr_ready    capture write handshake
//   wr_addr, wr_data      capture write word address and four pixels
//   flush                 drop every buffered write (frame restart)
//   mem_en, mem_we        RAM strobe and write enable
//   mem_addr, mem_wdata   RAM address and write data
//   mem_rdata             RAM read data, valid the cycle after a read strobe
//   wr_starved            sticky: a buffered write waited STARVE_MAX cycles
//   wr_overflow           sticky: a write beat was dropped on a full buffer
module fb_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int WBUF_DEPTH = 4,
    parameter int STARVE_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [3:0]        rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wdata,
    input  logic [3:0]        mem_rdata,
    output logic              wr_starved,
    output logic              wr_overflow
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Write buffer storage; entries only change on an accepted push.
    logic [ADDR_W-1:0] buf_addr_q [WBUF_DEPTH];
    logic [3:0]        buf_data_q [WBUF_DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              starved_q, starved_d;
    logic              overflow_q, overflow_d;

    // Read pipeline: s1 = RAM strobe cycle, s2 = RAM data cycle.
    logic              rd_s1_q, rd_s1_d;
    logic              rd_s2_q, rd_s2_d;
    logic              rd_valid_q, rd_valid_d;
    logic [3:0]        rd_data_q, rd_data_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wdata_q, mem_wdata_d;

    logic              fifo_empty;
    logic              push;
    logic              pop;

    always_comb begin
        fifo_empty = (count_q == '0);
        wr_ready   = (count_q < CW'(WBUF_DEPTH));

        // Flush freezes the queue for its cycle: nothing enters, nothing leaves.
        push = wr_valid && wr_ready && !flush;
        // A write only takes the port when no read is being scheduled.
        pop  = !rd_req && !fifo_empty && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Counts cycles a non-empty queue goes without draining; saturates.
        starve_d = starve_q;
        if (flush || fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        starved_d  = starved_q || (starve_d == SW'(STARVE_MAX));
        overflow_d = overflow_q || (wr_valid && !wr_ready);

        // RAM port: addr/wdata hold their last values when idle.
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr;
        end else if (pop) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = buf_addr_q[rd_ptr_q];
            mem_wdata_d = buf_data_q[rd_ptr_q];
        end

        rd_s1_d    = rd_req;
        rd_s2_d    = rd_s1_q;
        rd_valid_d = rd_s2_q;
        rd_data_d  = rd_s2_q ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= wr_addr;
            buf_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            starved_q   <= 1'b0;
            overflow_q  <= 1'b0;
            rd_s1_q     <= 1'b0;
            rd_s2_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            starved_q   <= starved_d;
            overflow_q  <= overflow_d;
            rd_s1_q     <= rd_s1_d;
            rd_s2_q     <= rd_s2_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wr_starved  = starved_q;
    assign wr_overflow = overflow_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed testbench for fb_arbiter. Inputs change and outputs are observed
// on the falling edge; the DUT samples on the rising edge.
module tb_fb_arbiter;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [3:0]        rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              flush;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wdata;
    logic [3:0]        mem_rdata;
    logic              wr_starved;
    logic              wr_overflow;

    int total = 0;
    int bad   = 0;

    fb_arbiter #(.ADDR_W(ADDR_W), .WBUF_DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .wr_starved(wr_starved), .wr_overflow(wr_overflow)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten words read back a fixed address-derived pattern.
    logic [3:0] ram    [1 << ADDR_W];
    bit         ram_wr [1 << ADDR_W];

    function automatic logic [3:0] init_val(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'hA;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en: got %0b want 0", mem_en); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        total++; if (mem_wdata !== 4'h0) begin bad++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
        total++; if (rd_data !== 4'h0) begin bad++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %0b want 1", wr_ready); end
        total++; if (wr_starved !== 1'b0) begin bad++; $display("FAIL reset_wr_starved: got %0b want 0", wr_starved); end
        total++; if (wr_overflow !== 1'b0) begin bad++; $display("FAIL reset_wr_overflow: got %0b want 0", wr_overflow); end
        rst = 1'b0;
    endtask

    // Single read of 0x0123; the RAM pattern there is 4'hA.
    task automatic test_read();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 15'h0123;
        cyc();
        rd_req = 1'b0;
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL read_t1_en: got %0b want 1", mem_en); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL read_t1_we: got %0b want 0", mem_we); end
        total++; if (mem_addr !== 15'h0123) begin bad++; $display("FAIL read_t1_addr: got %0h want 123", mem_addr); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_t1_valid: got %0b want 0", rd_valid); end
        cyc();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_t2_valid: got %0b want 0", rd_valid); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL read_t2_idle_en: got %0b want 0", mem_en); end
        cyc();
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL read_t3_valid: got %0b want 1", rd_valid); end
        total++; if (rd_data !== 4'hA) begin bad++; $display("FAIL read_t3_data: got %0h want a", rd_data); end
        cyc();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL read_t4_valid: got %0b want 0", rd_valid); end
        total++; if (mem_addr !== 15'h0123) begin bad++; $display("FAIL read_idle_addr_hold: got %0h want 123", mem_addr); end
    endtask

    // Reads every other cycle with writes pending: writes take the gaps in order.
    task automatic test_interleave();
        int rq [8]  = '{1, 0, 1, 0, 1, 0, 0, 0};
        int ra [8]  = '{'h500, 0, 'h502, 0, 'h504, 0, 0, 0};
        int wv [8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        int wa [8]  = '{'h60, 'h61, 'h62, 0, 0, 0, 0, 0};
        int wd [8]  = '{7, 8, 9, 0, 0, 0, 0, 0};
        int een [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        int ewe [8] = '{0, 1, 0, 1, 0, 1, 0, 0};
        int ead [8] = '{'h500, 'h60, 'h502, 'h61, 'h504, 'h62, 'h62, 'h62};
        int ewd [8] = '{0, 7, 0, 8, 0, 9, 0, 0};
        int erv [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        int erd [8] = '{0, 0, 'hF, 0, 'hD, 0, 'hB, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rd_req   = rq[i][0];
            rd_addr  = ra[i][ADDR_W-1:0];
            wr_valid = wv[i][0];
            wr_addr  = wa[i][ADDR_W-1:0];
            wr_data  = wd[i][3:0];
            cyc();
            total++; if (mem_en !== een[i][0]) begin bad++; $display("FAIL ilv_en[%0d]: got %0b want %0b", i, mem_en, een[i][0]); end
            total++; if (mem_we !== ewe[i][0]) begin bad++; $display("FAIL ilv_we[%0d]: got %0b want %0b", i, mem_we, ewe[i][0]); end
            total++; if (mem_addr !== ead[i][ADDR_W-1:0]) begin bad++; $display("FAIL ilv_addr[%0d]: got %0h want %0h", i, mem_addr, ead[i]); end
            if (ewe[i] != 0) begin
                total++; if (mem_wdata !== ewd[i][3:0]) begin bad++; $display("FAIL ilv_wdata[%0d]: got %0h want %0h", i, mem_wdata, ewd[i]); end
            end
            total++; if (rd_valid !== erv[i][0]) begin bad++; $display("FAIL ilv_rv[%0d]: got %0b want %0b", i, rd_valid, erv[i][0]); end
            if (erv[i] != 0) begin
                total++; if (rd_data !== erd[i][3:0]) begin bad++; $display("FAIL ilv_rdata[%0d]: got %0h want %0h", i, rd_data, erd[i]); end
            end
        end
        idle_inputs();
    endtask

    // Buffered write to an address read in the same cycle: the read sees old data.
    task automatic test_no_forward();
        do_reset();
        rd_req   = 1'b1;
        rd_addr  = 15'h0700;
        wr_valid = 1'b1;
        wr_addr  = 15'h0700;
        wr_data  = 4'hF;
        cyc();
        idle_inputs();
        cyc();
        cyc();
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL raw_valid: got %0b want 1", rd_valid); end
        total++; if (rd_data !== 4'hD) begin bad++; $display("FAIL raw_old_data: got %0h want d", rd_data); end
        rd_req  = 1'b1;
        rd_addr = 15'h0700;
        cyc();
        rd_req = 1'b0;
        cyc();
        cyc();
        total++; if (rd_data !== 4'hF) begin bad++; $display("FAIL raw_new_data: got %0h want f", rd_data); end
    endtask

    // STARVE_MAX=4: one write held off by a read every cycle.
    task automatic test_starve();
        do_reset();
        rd_req   = 1'b1;
        rd_addr  = 15'h0200;
        wr_valid = 1'b1;
        wr_addr  = 15'h0010;
        wr_data  = 4'h3;
        cyc();
        wr_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            total++; if (wr_starved !== 1'b0) begin bad++; $display("FAIL starve_early[%0d]: got %0b want 0", i, wr_starved); end
        end
        cyc();
        total++; if (wr_starved !== 1'b1) begin bad++; $display("FAIL starve_set: got %0b want 1", wr_starved); end
        rd_req = 1'b0;
        cyc();
        total++; if (mem_we !== 1'b1 || mem_addr !== 15'h0010 || mem_wdata !== 4'h3) begin
            bad++; $display("FAIL starve_drain: got we=%0b addr=%0h data=%0h want we=1 addr=10 data=3", mem_we, mem_addr, mem_wdata);
        end
        cyc();
        total++; if (wr_starved !== 1'b1) begin bad++; $display("FAIL starve_sticky: got %0b want 1", wr_starved); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL starve_idle_en: got %0b want 0", mem_en); end
    endtask

    // Five write beats while reads are held on every cycle so nothing drains.
    task automatic test_fill();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 15'h0300;
        for (int i = 0; i < 5; i++) begin
            total++; if (wr_ready !== (i < 4)) begin bad++; $display("FAIL fill_ready[%0d]: got %0b want %0b", i, wr_ready, (i < 4)); end
            wr_valid = 1'b1;
            wr_addr  = 15'h0040 + 15'(i);
            wr_data  = 4'(i + 1);
            cyc();
            if (i == 3) begin
                total++; if (wr_overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf: got %0b want 0", wr_overflow); end
            end
        end
        total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf: got %0b want 1", wr_overflow); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h0040 + 15'(i) || mem_wdata !== 4'(i + 1)) begin
                bad++; $display("FAIL fill_drain[%0d]: got en=%0b we=%0b addr=%0h data=%0h want en=1 we=1 addr=%0h data=%0h",
                                i, mem_en, mem_we, mem_addr, mem_wdata, 15'h0040 + 15'(i), 4'(i + 1));
            end
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after[%0d]: got %0b want 1", i, wr_ready); end
        end
        cyc();
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL fill_dropped_beat: got en=%0b addr=%0h want en=0", mem_en, mem_addr); end
        total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf_sticky: got %0b want 1", wr_overflow); end
    endtask

    // Three entries buffered, then flush: none of them reaches the RAM.
    task automatic test_flush();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 15'h0300;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 15'h0090 + 15'(i);
            wr_data  = 4'(i + 5);
            cyc();
        end
        rd_req  = 1'b0;
        flush   = 1'b1;
        wr_addr = 15'h00AA;
        cyc();
        idle_inputs();
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %0b want 1", wr_ready); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL flush_no_we[%0d]: got %0b want 0 addr=%0h", i, mem_we, mem_addr); end
            cyc();
        end
        wr_valid = 1'b1;
        wr_addr  = 15'h0080;
        wr_data  = 4'h6;
        cyc();
        wr_valid = 1'b0;
        cyc();
        total++; if (mem_we !== 1'b1 || mem_addr !== 15'h0080 || mem_wdata !== 4'h6) begin
            bad++; $display("FAIL flush_then_write: got we=%0b addr=%0h data=%0h want we=1 addr=80 data=6", mem_we, mem_addr, mem_wdata);
        end
    endtask

    // Reset one cycle after a read request kills that read's return.
    task automatic test_reset_mid_read();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 15'h0123;
        cyc();
        rd_req = 1'b0;
        rst    = 1'b1;
        cyc();
        rst = 1'b0;
        total++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 4'h0) begin
            bad++; $display("FAIL rstmid_mem: got en=%0b we=%0b addr=%0h data=%0h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
        total++; if (rd_valid !== 1'b0 || rd_data !== 4'h0 || wr_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_outs: got rv=%0b rd=%0h rdy=%0b want rv=0 rd=0 rdy=1", rd_valid, rd_data, wr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_valid[%0d]: got %0b want 0", i, rd_valid); end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_read();
        test_interleave();
        test_no_forward();
        test_starve();
        test_fill();
        test_flush();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
